// File: rtl/af_cluster_stream.sv
`default_nettype none
// ============================================================================
// Module      : af_cluster_stream
// Description : Multi-channel, two-stage pipelined activation-function
//               cluster. Stage S1 applies the per-beat activation (ReLU,
//               bypass, leaky ReLU, clipped ReLU) to every lane. Stage S2
//               requantises each lane with a round-half-up arithmetic right
//               shift and saturates it to OUT_BITWIDTH, flagging any clamp.
//               Configuration travels with its beat through the pipe.
// Ports       : clk_i        - clock, rising-edge active
//               rst_i        - synchronous active-high reset
//               mode_i       - activation select (0 ReLU, 1 bypass,
//                              2 leaky, 3 clipped, >= MODES bypass)
//               shift_i      - requantisation right-shift amount
//               leak_shift_i - leaky slope shift for negative inputs
//               clip_i       - unsigned upper bound used by clipped mode
//               data_i       - CHANNELS packed signed input lanes
//               enable_i     - input valid
//               ready_o      - input ready (combinational from ready_i)
//               data_o       - CHANNELS packed signed output lanes
//               sat_o        - per-lane saturation flag
//               enable_o     - output valid
//               ready_i      - downstream ready
// Revision    : 1.0 - initial release
// ============================================================================
module af_cluster_stream #(
    parameter int DATA_BITWIDTH  = 20,
    parameter int OUT_BITWIDTH   = 8,
    parameter int CHANNELS       = 4,
    parameter int MODES          = 4,
    parameter int SHIFT_BITWIDTH = 5
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [$clog2(MODES)-1:0]          mode_i,
    input  logic [SHIFT_BITWIDTH-1:0]         shift_i,
    input  logic [SHIFT_BITWIDTH-1:0]         leak_shift_i,
    input  logic [OUT_BITWIDTH-2:0]           clip_i,
    input  logic [CHANNELS*DATA_BITWIDTH-1:0] data_i,
    input  logic                              enable_i,
    output logic                              ready_o,
    output logic [CHANNELS*OUT_BITWIDTH-1:0]  data_o,
    output logic [CHANNELS-1:0]               sat_o,
    output logic                              enable_o,
    input  logic                              ready_i
);

    localparam logic [31:0] c_MODE_RELU  = 32'd0;
    localparam logic [31:0] c_MODE_LEAKY = 32'd2;
    localparam logic [31:0] c_MODE_CLIP  = 32'd3;

    // Output range expressed at the S2 working width (DATA_BITWIDTH+1).
    localparam logic signed [DATA_BITWIDTH:0] c_OUT_MAX =
        (DATA_BITWIDTH+1)'(2**(OUT_BITWIDTH-1) - 1);
    localparam logic signed [DATA_BITWIDTH:0] c_OUT_MIN =
        (DATA_BITWIDTH+1)'(-(2**(OUT_BITWIDTH-1)));

    // ------------------------------------------------------------------
    // Handshake / advance
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic w_adv1;
    logic w_adv2;

    assign w_adv2   = !r_v2 || ready_i;
    assign w_adv1   = !r_v1 || w_adv2;
    assign ready_o  = w_adv1 && !rst_i;
    assign enable_o = r_v2;

    // ------------------------------------------------------------------
    // Mode decode (values outside the implemented set behave as bypass)
    // ------------------------------------------------------------------
    logic [31:0] w_mode_ext;
    logic        w_mode_ok;
    logic        w_relu;
    logic        w_leaky;
    logic        w_clip_en;

    assign w_mode_ext = 32'(mode_i);
    assign w_mode_ok  = w_mode_ext < MODES;
    assign w_relu     = w_mode_ok && (w_mode_ext == c_MODE_RELU || w_mode_ext == c_MODE_CLIP);
    assign w_leaky    = w_mode_ok && (w_mode_ext == c_MODE_LEAKY);
    assign w_clip_en  = w_mode_ok && (w_mode_ext == c_MODE_CLIP);

    // ------------------------------------------------------------------
    // S1 registers: activated lanes plus the config S2 still needs
    // ------------------------------------------------------------------
    logic [CHANNELS*DATA_BITWIDTH-1:0] w_act_all;
    logic [CHANNELS*DATA_BITWIDTH-1:0] r_act1;
    logic [SHIFT_BITWIDTH-1:0]         r_shift1;
    logic [OUT_BITWIDTH-2:0]           r_clip1;
    logic                              r_clip_en1;

    // S2 results and registers
    logic [CHANNELS*OUT_BITWIDTH-1:0]  w_out_all;
    logic [CHANNELS-1:0]               w_sat_all;
    logic [CHANNELS*OUT_BITWIDTH-1:0]  r_data2;
    logic [CHANNELS-1:0]               r_sat2;

    // Shifts at or beyond the data width collapse to the sign of the input.
    logic w_shift_big;
    assign w_shift_big = 32'(r_shift1) >= DATA_BITWIDTH;

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_lane
            // ---------------- S1: activation ----------------
            logic signed [DATA_BITWIDTH-1:0] w_x;
            logic signed [DATA_BITWIDTH-1:0] w_act;

            assign w_x = data_i[k*DATA_BITWIDTH +: DATA_BITWIDTH];

            always_comb begin
                w_act = w_x;
                if (w_x[DATA_BITWIDTH-1]) begin
                    if (w_relu) begin
                        w_act = '0;
                    end else if (w_leaky) begin
                        w_act = w_x >>> leak_shift_i;
                    end
                end
            end

            assign w_act_all[k*DATA_BITWIDTH +: DATA_BITWIDTH] = w_act;

            // ---------------- S2: requantise + saturate ----------------
            // One extra bit of headroom so the rounding add cannot wrap.
            logic signed [DATA_BITWIDTH-1:0] w_a;
            logic signed [DATA_BITWIDTH:0]   w_ae;
            logic signed [DATA_BITWIDTH:0]   w_rnd;
            logic signed [DATA_BITWIDTH:0]   w_y;
            logic signed [DATA_BITWIDTH:0]   w_hi;
            logic signed [DATA_BITWIDTH:0]   w_q;
            logic                            w_sat;

            assign w_a  = r_act1[k*DATA_BITWIDTH +: DATA_BITWIDTH];
            assign w_ae = {w_a[DATA_BITWIDTH-1], w_a};

            always_comb begin
                w_rnd = '0;
                if (r_shift1 != '0) begin
                    w_rnd = (DATA_BITWIDTH+1)'(1) << (r_shift1 - SHIFT_BITWIDTH'(1));
                end
                if (w_shift_big) begin
                    w_y = w_ae[DATA_BITWIDTH] ? '1 : '0;
                end else begin
                    w_y = (w_ae + w_rnd) >>> r_shift1;
                end
            end

            // Clip bound is narrower than the output range, so in clipped
            // mode it simply replaces the upper limit.
            assign w_hi = r_clip_en1 ? (DATA_BITWIDTH+1)'(r_clip1) : c_OUT_MAX;

            always_comb begin
                w_q   = w_y;
                w_sat = 1'b0;
                if (w_y > w_hi) begin
                    w_q   = w_hi;
                    w_sat = 1'b1;
                end else if (w_y < c_OUT_MIN) begin
                    w_q   = c_OUT_MIN;
                    w_sat = 1'b1;
                end
            end

            assign w_out_all[k*OUT_BITWIDTH +: OUT_BITWIDTH] = w_q[OUT_BITWIDTH-1:0];
            assign w_sat_all[k] = w_sat;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_act1     <= '0;
            r_shift1   <= '0;
            r_clip1    <= '0;
            r_clip_en1 <= 1'b0;
            r_data2    <= '0;
            r_sat2     <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= enable_i;
                if (enable_i) begin
                    r_act1     <= w_act_all;
                    r_shift1   <= shift_i;
                    r_clip1    <= clip_i;
                    r_clip_en1 <= w_clip_en;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_data2 <= w_out_all;
                    r_sat2  <= w_sat_all;
                end
            end
        end
    end

    assign data_o = r_data2;
    assign sat_o  = r_sat2;

endmodule
`default_nettype wire

// File: tb/tb_af_cluster_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_af_cluster_stream
// Description : Self-checking bench for af_cluster_stream (4 lanes, 20-bit
//               in, 8-bit out). Expected beats are queued on input transfer
//               and compared on output transfer; directed checks cover
//               reset, latency, stall hold and mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_af_cluster_stream;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  mode_i;
    logic [4:0]  shift_i;
    logic [4:0]  leak_shift_i;
    logic [6:0]  clip_i;
    logic [79:0] data_i;
    logic        enable_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic [3:0]  sat_o;
    logic        enable_o;
    logic        ready_i;

    af_cluster_stream #(
        .DATA_BITWIDTH (20),
        .OUT_BITWIDTH  (8),
        .CHANNELS      (4),
        .MODES         (4),
        .SHIFT_BITWIDTH(5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .mode_i      (mode_i),
        .shift_i     (shift_i),
        .leak_shift_i(leak_shift_i),
        .clip_i      (clip_i),
        .data_i      (data_i),
        .enable_i    (enable_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .sat_o       (sat_o),
        .enable_o    (enable_o),
        .ready_i     (ready_i)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [35:0] q[$];       // {data[31:0], sat[3:0]}

    function automatic logic [79:0] pk(input int l0, input int l1, input int l2, input int l3);
        logic [79:0] r;
        r[19:0]  = l0[19:0];
        r[39:20] = l1[19:0];
        r[59:40] = l2[19:0];
        r[79:60] = l3[19:0];
        return r;
    endfunction

    // Reference model written straight from the activation/requant rules.
    function automatic logic [35:0] model(input logic [1:0] m, input logic [4:0] sh,
                                          input logic [4:0] ls, input logic [6:0] cl,
                                          input logic [79:0] d);
        logic [31:0]        od;
        logic [3:0]         os;
        logic signed [19:0] xs;
        longint             x, a, y, hi;
        for (int k = 0; k < 4; k++) begin
            xs = d[k*20 +: 20];
            x  = xs;
            case (m)
                2'd0, 2'd3: a = (x < 0) ? 0 : x;
                2'd2:       a = (x < 0) ? (x >>> ls) : x;
                default:    a = x;
            endcase
            if (sh >= 20) begin
                y = (a < 0) ? -1 : 0;
            end else begin
                y = a;
                if (sh > 0) y = y + (longint'(1) << (sh - 1));
                y = y >>> sh;
            end
            hi    = (m == 2'd3) ? longint'(cl) : 127;
            os[k] = 1'b0;
            if (y > hi) begin
                y = hi; os[k] = 1'b1;
            end else if (y < -128) begin
                y = -128; os[k] = 1'b1;
            end
            od[k*8 +: 8] = y[7:0];
        end
        return {od, os};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compares at every output transfer.
    logic [35:0] mon_e;
    always @(negedge clk) begin
        if (enable_o === 1'b1 && ready_i === 1'b1) begin
            n_out++;
            n_cmp++;
            assert (q.size() > 0) else begin
                n_err++;
                $error("FAIL spurious_out: observed data=%h expected no beat", data_o);
            end
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                n_cmp++;
                assert (data_o === mon_e[35:4]) else begin
                    n_err++;
                    $error("FAIL out_data: observed %h expected %h", data_o, mon_e[35:4]);
                end
                n_cmp++;
                assert (sat_o === mon_e[3:0]) else begin
                    n_err++;
                    $error("FAIL out_sat: observed %b expected %b", sat_o, mon_e[3:0]);
                end
            end
        end
    end

    // Drive one beat from posedge+1, wait (bounded) for acceptance, queue
    // its expected result, and return at posedge+1 after the transfer edge.
    task automatic send(input logic [1:0] m, input logic [4:0] sh, input logic [4:0] ls,
                        input logic [6:0] cl, input logic [79:0] d, input logic [35:0] e);
        logic acc;
        mode_i = m; shift_i = sh; leak_shift_i = ls; clip_i = cl; data_i = d;
        enable_i = 1'b1;
        acc = 1'b0;
        for (int w = 0; w < 50 && !acc; w++) begin
            @(negedge clk);
            acc = ready_o;
        end
        chk("send_accept", acc, 1);
        if (acc) q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int w = 0; w < 100 && q.size() != 0; w++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    logic [1:0]  smode[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [79:0] sdat[6];
    logic [31:0] hold_d;
    logic [3:0]  hold_s;
    logic [79:0] rd;
    logic [1:0]  rm;
    logic [4:0]  rs, rl;
    logic [6:0]  rc;
    int          b;
    int          n0;

    initial begin
        // ---------------- reset with live input ----------------
        rst_i = 1'b1; enable_i = 1'b1; ready_i = 1'b1;
        mode_i = 2'd1; shift_i = 5'd0; leak_shift_i = 5'd0; clip_i = 7'd0;
        data_i = pk(11, 22, 33, 44);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_enable_o", enable_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_sat_o", sat_o, 0);
        chk("rst_ready_o", ready_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0; enable_i = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", ready_o, 1);
        repeat (3) begin
            @(negedge clk);
            chk("no_spurious_after_rst", enable_o, 0);
        end
        @(posedge clk); #1;

        // ---------------- latency + ReLU saturation ----------------
        send(2'd0, 5'd0, 5'd0, 7'd0, pk(-5, 100, 0, 524287),
             {8'd127, 8'd0, 8'd100, 8'd0, 4'b1000});
        enable_i = 1'b0;
        @(negedge clk); chk("latency_s1", enable_o, 0);
        @(negedge clk); chk("latency_s2", enable_o, 1);
        @(posedge clk); #1;

        // ---------------- directed function beats, back to back ----------------
        send(2'd0, 5'd4, 5'd0, 7'd0, pk(100, 8, 7, 24),
             {8'd2, 8'd0, 8'd1, 8'd6, 4'b0000});
        send(2'd1, 5'd0, 5'd0, 7'd0, pk(-524288, 0, 0, 0),
             {8'h00, 8'h00, 8'h00, 8'h80, 4'b0001});
        send(2'd2, 5'd0, 5'd2, 7'd0, pk(-100, -1, 50, -600),
             {8'h80, 8'd50, 8'hFF, 8'hE7, 4'b1000});
        send(2'd3, 5'd0, 5'd0, 7'd6, pk(3, 10, -4, 6),
             {8'd6, 8'd0, 8'd6, 8'd3, 4'b0010});
        // round-half-up on both signs
        send(2'd1, 5'd1, 5'd0, 7'd0, pk(3, -3, 1, -1),
             {8'h00, 8'h01, 8'hFF, 8'h02, 4'b0000});
        // largest in-range shift: rounding add needs the extra bit
        send(2'd1, 5'd19, 5'd0, 7'd0, pk(524287, -524288, 262144, 262143),
             {8'h00, 8'h01, 8'hFF, 8'h01, 4'b0000});
        // shift equal to data width collapses to sign
        send(2'd1, 5'd20, 5'd0, 7'd0, pk(-524288, 524287, 1, -1),
             {8'hFF, 8'h00, 8'h00, 8'hFF, 4'b0000});
        enable_i = 1'b0;
        drain();

        // ---------------- stall: 6 beats, ready_i low 3 cycles ----------------
        for (int i = 0; i < 6; i++) sdat[i] = {$urandom, $urandom, $urandom};
        b = 0;
        for (int c = 0; c < 40 && b < 6; c++) begin
            ready_i = !(c >= 2 && c <= 4);
            mode_i = smode[b]; shift_i = 5'(b); leak_shift_i = 5'(b + 1);
            clip_i = 7'(20 + b); data_i = sdat[b]; enable_i = 1'b1;
            @(negedge clk);
            if (c == 2) begin
                chk("stall_ready_drop", ready_o, 0);
                chk("stall_valid", enable_o, 1);
                hold_d = data_o; hold_s = sat_o;
            end
            if (c == 3 || c == 4) begin
                chk("stall_hold_valid", enable_o, 1);
                chk("stall_hold_data", data_o, hold_d);
                chk("stall_hold_sat", sat_o, hold_s);
                chk("stall_ready_low", ready_o, 0);
            end
            if (c == 5) chk("stall_full_shift_ready", ready_o, 1);
            if (ready_o) begin
                q.push_back(model(smode[b], 5'(b), 5'(b + 1), 7'(20 + b), sdat[b]));
                b++;
            end
            @(posedge clk); #1;
        end
        enable_i = 1'b0; ready_i = 1'b1;
        chk("stall_all_sent", b, 6);
        drain();

        // ---------------- continuous stream: one beat per cycle ----------------
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            rd = {$urandom, $urandom, $urandom};
            rm = 2'($urandom_range(0, 3)); rs = 5'($urandom_range(0, 22));
            rl = 5'($urandom_range(0, 22)); rc = 7'($urandom_range(0, 127));
            mode_i = rm; shift_i = rs; leak_shift_i = rl; clip_i = rc; data_i = rd;
            enable_i = 1'b1;
            @(negedge clk);
            chk("stream_ready", ready_o, 1);
            if (i >= 2) chk("stream_valid", enable_o, 1);
            if (ready_o) q.push_back(model(rm, rs, rl, rc, rd));
            @(posedge clk); #1;
        end
        enable_i = 1'b0;
        drain();
        chk("stream_count", n_out - n0, 8);

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 4; i++) begin
            rd = {$urandom, $urandom, $urandom};
            rm = 2'($urandom_range(0, 3)); rs = 5'($urandom_range(0, 10));
            mode_i = rm; shift_i = rs; leak_shift_i = 5'd1; clip_i = 7'd50; data_i = rd;
            enable_i = 1'b1;
            @(negedge clk);
            if (ready_o) q.push_back(model(rm, rs, 5'd1, 7'd50, rd));
            @(posedge clk); #1;
        end
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_ready_low", ready_o, 0);
        @(posedge clk); #1;
        q.delete();
        rst_i = 1'b0; enable_i = 1'b0;
        @(negedge clk);
        chk("midrst_enable_o", enable_o, 0);
        chk("midrst_data_o", data_o, 0);
        chk("midrst_ready", ready_o, 1);
        @(posedge clk); #1;
        n0 = n_out;
        send(2'd2, 5'd1, 5'd3, 7'd0, pk(-64, 64, -1, 300), model(2'd2, 5'd1, 5'd3, 7'd0, pk(-64, 64, -1, 300)));
        send(2'd3, 5'd2, 5'd0, 7'd9, pk(100, -100, 36, 35), model(2'd3, 5'd2, 5'd0, 7'd9, pk(100, -100, 36, 35)));
        send(2'd0, 5'd0, 5'd0, 7'd0, pk(-1, 1, -2, 2), {8'd2, 8'd0, 8'd1, 8'd0, 4'b0000});
        enable_i = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        chk("midrst_post_count", n_out - n0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/af_cluster_stream.md
Name: af_cluster_stream

Overview:
Multi-channel, pipelined activation-function cluster. It sits between the PE-array accumulator output and the activation write-back path. It applies a selectable activation function to CHANNELS signed accumulator words in parallel, then requantises each word (rounding right shift plus saturation) to OUT_BITWIDTH. It is the parametrised successor of the single-channel ReLU/pass-through af_cluster, adding a valid/ready pipeline, configuration carried per beat, leaky and clipped modes, and saturation flags.

Parameters:
- DATA_BITWIDTH, 20: signed input word width per channel.
- OUT_BITWIDTH, 8: signed output word width per channel; must be ≤ DATA_BITWIDTH.
- CHANNELS, 4: parallel lanes; must be ≥ 1.
- MODES, 4: number of activation modes; mode_i width is $clog2(MODES).
- SHIFT_BITWIDTH, 5: width of shift_i and leak_shift_i.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mode_i  in  $clog2(MODES)  activation select. 0 = ReLU, 1 = bypass, 2 = leaky ReLU, 3 = clipped ReLU.
- shift_i  in  SHIFT_BITWIDTH  requantisation right-shift amount.
- leak_shift_i  in  SHIFT_BITWIDTH  leaky slope: a negative x maps to x>>>leak_shift_i.
- clip_i  in  OUT_BITWIDTH-1  unsigned upper bound for mode 3.
- data_i  in  CHANNELS*DATA_BITWIDTH  input lanes; lane k is at bits [k*DATA_BITWIDTH +: DATA_BITWIDTH].
- enable_i  in  1  input valid.
- ready_o  out  1  block can accept a beat.
- data_o  out  CHANNELS*OUT_BITWIDTH  output lanes, packed the same way as data_i.
- sat_o  out  CHANNELS  per-lane flag: the beat was clamped by saturation.
- enable_o  out  1  output valid.
- ready_i  in  1  downstream can accept a beat.

Behaviour:
- Handshake:
  - A beat transfers on an input when enable_i && ready_o.
  - A beat transfers on the output when enable_o && ready_i.
- Configuration sampling: mode_i, shift_i, leak_shift_i and clip_i are sampled together with data_i at input transfer and travel with that beat. Changing them between beats has no effect on beats already in flight.
- Pipeline:
  - Two register stages, S1 and S2, each with its own valid bit.
  - Latency is 2 cycles from input transfer to enable_o when the pipe is not stalled.
  - Throughput is 1 beat per cycle.
- Advance rules:
  - adv2 = !v2 || ready_i.
  - adv1 = !v1 || adv2.
  - ready_o = adv1 && !rst_i. This is a combinational path from ready_i.
- S1 (activation, DATA_BITWIDTH signed, per lane):
  - ReLU: x<0 → 0, otherwise x.
  - Bypass: x.
  - Leaky: x<0 → x>>>leak_shift_i (arithmetic shift, floor), otherwise x.
  - Clipped: same as ReLU.
  - Mode values ≥ MODES: treat as bypass.
- S2 (requantisation):
  - Compute at DATA_BITWIDTH+1 bits: y = (a + (shift_i>0 ? 1<<(shift_i-1) : 0)) >>> shift_i. This is round-half-up.
  - shift_i ≥ DATA_BITWIDTH yields 0 for a ≥ 0 and -1 for a < 0, with no rounding add.
- Saturation:
  - Clamp y to [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1].
  - Mode 3 additionally clamps the upper bound to clip_i.
  - sat_o[k] = 1 if either clamp changed lane k.
- Stall: while enable_o && !ready_i, data_o, sat_o and enable_o hold stable. S1 fills, then ready_o drops. No beat is lost or duplicated, and order is preserved.
- Simultaneous events:
  - Input and output transfer in the same cycle with both stages full: all stages shift and ready_o stays 1.
  - Input transfer into an empty pipe while the output transfers is legal.
- Reset:
  - While rst_i is high: v1 = v2 = 0, enable_o = 0, data_o = 0, sat_o = 0, ready_o = 0.
  - From the first cycle after rst_i deasserts: ready_o = 1.
  - Reset mid-stream discards all in-flight beats, and enable_o is 0 at the clock edge where reset is sampled.
- Lane data_o and sat_o contents are don't-care when enable_o = 0, except that they are 0 after reset.

Test Plan:
- Reset with enable_i=1 and data nonzero → enable_o=0, data_o=0, sat_o=0, ready_o=0. After release, ready_o=1 and no spurious output.
- ReLU, shift 0, lanes {-5, 100, 0, 524287} → 2 cycles later lanes {0, 100, 0, 127}, sat_o=4'b1000.
- ReLU, shift 4, lanes {100, 8, 7, 24} → {6, 1, 0, 2}, sat_o=0. Bypass, shift 0, lane -524288 → -128 with sat=1.
- Leaky, leak_shift 2, shift 0, lanes {-100, -1, 50, -600} → {-25, -1, 50, -128}, sat_o=4'b1000. Clipped, clip_i=6, shift 0, lanes {3, 10, -4, 6} → {3, 6, 0, 6}, sat_o=4'b0010.
- Stream of 6 beats with distinct modes each beat; ready_i low for 3 cycles after the first output → ready_o drops once S1 and S2 are full, outputs hold stable, and all 6 beats emerge in order, each with its own mode applied.
- Continuous stream with ready_i=1 → one output per cycle. Assert rst_i for 1 cycle mid-stream → enable_o=0 next cycle, and only beats accepted after reset appear.
